// File: rtl/multicycle_ctrl_pkg.sv
// Shared state encodings and opcode constants for the multicycle controller.
// Both the controller and its bench import this package.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB controls,
// memory-wait timeout with a sticky error flag, and a retired-instruction count.
//
//   state  | meaning
//   FETCH  | load IR and bump PC when RUN is high
//   DECODE | opcode latched, no controls
//   EXEC   | ALU op; J updates PC and retires here
//   MEM    | hold read/write strobe until MEM_READY or timeout
//   WB     | register write for ADD / LW
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic [7:0] INSTR,
  input  logic       MEM_READY,
  output logic       IR_WRITE,
  output logic       PC_WRITE,
  output logic       PC_SRC,
  output logic       REGDST,
  output logic       REGWRITE,
  output logic       ALUSRC,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       MEMTOREG,
  output logic [2:0] STATE,
  output logic [7:0] INSTR_CNT,
  output logic       ERR
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  // Timeout fires on the MEM cycle whose stalled increment would reach the limit.
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  state_t          state_q, state_d;
  opcode_t         opcode_q;
  logic [WW-1:0]   wait_q;
  logic            retire;
  logic            timeout;

  assign STATE = state_q;

  always_comb begin
    state_d   = state_q;
    IR_WRITE  = 1'b0;
    PC_WRITE  = 1'b0;
    PC_SRC    = 1'b0;
    REGDST    = 1'b0;
    REGWRITE  = 1'b0;
    ALUSRC    = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    MEMTOREG  = 1'b0;
    retire    = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (RUN) begin
          IR_WRITE = 1'b1;
          PC_WRITE = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode_q)
          OP_ADD: state_d = S_WB;
          OP_LW, OP_SW: begin
            ALUSRC  = 1'b1;
            state_d = S_MEM;
          end
          OP_J: begin
            PC_WRITE = 1'b1;
            PC_SRC   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        MEM_READ  = (opcode_q == OP_LW);
        MEM_WRITE = (opcode_q == OP_SW);
        // Ready takes priority over a timeout landing in the same cycle.
        if (MEM_READY) begin
          if (opcode_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        REGWRITE = 1'b1;
        REGDST   = (opcode_q == OP_ADD);
        MEMTOREG = (opcode_q == OP_LW);
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      opcode_q  <= OP_ADD;
      wait_q    <= '0;
      INSTR_CNT <= 8'd0;
      ERR       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && RUN) opcode_q <= opcode_t'(INSTR[7:6]);
      if (state_q == S_EXEC) wait_q <= '0;
      else if (state_q == S_MEM && !MEM_READY) wait_q <= wait_q + WW'(1);
      if (retire) INSTR_CNT <= INSTR_CNT + 8'd1;
      if (timeout) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expectations are queued
// from instruction latency/control tables and popped as the DUT steps.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int WAIT_MAX = 15;

  localparam logic [8:0] C_IR    = 9'h100;
  localparam logic [8:0] C_PCW   = 9'h080;
  localparam logic [8:0] C_PCSRC = 9'h040;
  localparam logic [8:0] C_RD    = 9'h020;
  localparam logic [8:0] C_RW    = 9'h010;
  localparam logic [8:0] C_ALU   = 9'h008;
  localparam logic [8:0] C_MR    = 9'h004;
  localparam logic [8:0] C_MW    = 9'h002;
  localparam logic [8:0] C_MTR   = 9'h001;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] ctrl;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_src, regdst, regwrite, alusrc;
  logic       mem_read, mem_write, memtoreg;
  logic [2:0] state;
  logic [7:0] instr_cnt;
  logic       err;
  logic [8:0] obs_ctrl;

  exp_t       q[$];
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_err = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign obs_ctrl = {ir_write, pc_write, pc_src, regdst, regwrite, alusrc,
                     mem_read, mem_write, memtoreg};

  multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .CLK(clk), .RST(rst), .RUN(run), .INSTR(instr), .MEM_READY(mem_ready),
    .IR_WRITE(ir_write), .PC_WRITE(pc_write), .PC_SRC(pc_src),
    .REGDST(regdst), .REGWRITE(regwrite), .ALUSRC(alusrc),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEMTOREG(memtoreg),
    .STATE(state), .INSTR_CNT(instr_cnt), .ERR(err)
  );

  task automatic push(input logic [2:0] st, input logic [8:0] c);
    exp_t e;
    e.st = st; e.ctrl = c; e.cnt = exp_cnt; e.err = exp_err;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle against the queue head.
  task automatic cycle(input logic run_i, input logic [7:0] instr_i, input logic ready_i);
    exp_t e;
    run = run_i; instr = instr_i; mem_ready = ready_i;
    @(negedge clk);
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d expected>0", q.size());
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (state === e.st) else begin
        errors++; $error("FAIL state: observed=%0d expected=%0d", state, e.st);
      end
      checks++;
      assert (obs_ctrl === e.ctrl) else begin
        errors++; $error("FAIL ctrl(state %0d): observed=%b expected=%b", e.st, obs_ctrl, e.ctrl);
      end
      checks++;
      assert (instr_cnt === e.cnt) else begin
        errors++; $error("FAIL instr_cnt: observed=%0d expected=%0d", instr_cnt, e.cnt);
      end
      checks++;
      assert (err === e.err) else begin
        errors++; $error("FAIL err: observed=%b expected=%b", err, e.err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Queue the cycle-by-cycle expectation for one instruction, then run it.
  // nwait = stalled MEM cycles before MEM_READY; tmo = MEM_READY never comes.
  task automatic do_instr(input logic [7:0] ins, input int nwait, input bit tmo);
    logic [1:0] op;
    int nmem, total;
    op = ins[7:6];
    nmem = 0;
    push(S_FETCH, C_IR | C_PCW);
    push(S_DECODE, 9'h000);
    case (op)
      2'(OP_ADD): push(S_EXEC, 9'h000);
      2'(OP_J):   push(S_EXEC, C_PCW | C_PCSRC);
      default:    push(S_EXEC, C_ALU);
    endcase
    if (op == 2'(OP_LW) || op == 2'(OP_SW)) begin
      nmem = tmo ? WAIT_MAX : nwait + 1;
      for (int k = 0; k < nmem; k++) push(S_MEM, (op == 2'(OP_LW)) ? C_MR : C_MW);
    end
    if (op == 2'(OP_ADD)) push(S_WB, C_RW | C_RD);
    if (op == 2'(OP_LW) && !tmo) push(S_WB, C_RW | C_MTR);
    total = 3 + nmem + ((op == 2'(OP_ADD) || (op == 2'(OP_LW) && !tmo)) ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      if (i == 0) cycle(1'b1, ins, 1'($urandom));
      else if (i >= 3 && i < 3 + nmem) cycle(1'($urandom), 8'($urandom), !tmo && (i - 3 == nwait));
      else cycle(1'($urandom), 8'($urandom), 1'($urandom));
    end
    if (tmo) exp_err = 1'b1;
    else exp_cnt = exp_cnt + 8'd1;
  endtask

  initial begin
    // Reset with RUN low: FETCH and all controls quiet.
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    push(S_FETCH, 9'h000); cycle(1'b0, 8'hFF, 1'b1);
    push(S_FETCH, 9'h000); cycle(1'b0, 8'h55, 1'b0);
    rst = 1'b0;

    do_instr(8'b00_01_10_11, 0, 1'b0);
    push(S_FETCH, 9'h000); cycle(1'b0, 8'h00, 1'b0);
    checks++;
    assert (instr_cnt === 8'd1) else begin
      errors++; $error("FAIL add_count: observed=%0d expected=1", instr_cnt);
    end

    do_instr(8'b01_00_01_10, 2, 1'b0);
    do_instr(8'b10_11_00_01, 0, 1'b0);
    do_instr(8'hC3, 0, 1'b0);
    do_instr(8'b01_10_01_11, WAIT_MAX - 1, 1'b0);
    do_instr(8'b10_01_10_00, 0, 1'b1);
    do_instr(8'b00_11_01_10, 0, 1'b0);
    push(S_FETCH, 9'h000); cycle(1'b0, 8'hA5, 1'b1);

    // Reset while an LW sits in MEM.
    push(S_FETCH, C_IR | C_PCW);
    push(S_DECODE, 9'h000);
    push(S_EXEC, C_ALU);
    push(S_MEM, C_MR);
    cycle(1'b1, 8'b01_00_01_10, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 8'hFF, 1'b0);
    rst = 1'b0;
    exp_cnt = 8'd0; exp_err = 1'b0;
    push(S_FETCH, 9'h000); cycle(1'b0, 8'h00, 1'b1);
    push(S_FETCH, 9'h000); cycle(1'b0, 8'h00, 1'b0);

    for (int n = 0; n < 256; n++) do_instr({2'b00, 6'($urandom)}, 0, 1'b0);
    push(S_FETCH, 9'h000); cycle(1'b0, 8'hC3, 1'b0);
    checks++;
    assert (instr_cnt === 8'd0) else begin
      errors++; $error("FAIL cnt_wrap: observed=%0d expected=0", instr_cnt);
    end

    for (int n = 0; n < 5; n++) begin
      push(S_FETCH, 9'h000);
      cycle(1'b0, 8'($urandom), 1'($urandom));
    end

    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL scoreboard_leftover: observed=%0d expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
